// File: rtl/led_pattern_gen.sv
// LED pattern engine: binary count, Gray count, bouncing scan and PWM breathe, stepped on a prescaler tick.
// Define LED_PATTERN_HOLD_EN to add a debounced i_btn_hold input that freezes pattern stepping while held.
module led_pattern_gen #(
  parameter int LED_W        = 8,
  parameter int PRESCALE_W   = 20,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int PWM_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_mode,
  input  logic             i_btn_dir,
`ifdef LED_PATTERN_HOLD_EN
  input  logic             i_btn_hold,
`endif
  output logic [LED_W-1:0] o_led,
  output logic [1:0]       o_mode,
  output logic             o_tick
);

`ifdef LED_PATTERN_HOLD_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;

  typedef enum logic [1:0] {MODE_COUNT, MODE_GRAY, MODE_SCAN, MODE_BREATHE} mode_e;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_level_q;
  logic [NBTN-1:0] btn_level_d;
  logic            mode_press;
  logic            dir_press;
  logic            hold;

`ifdef LED_PATTERN_HOLD_EN
  assign btn_raw = {i_btn_hold, i_btn_dir, i_btn_mode};
  assign hold    = btn_level_q[2];
`else
  assign btn_raw = {i_btn_dir, i_btn_mode};
  assign hold    = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic [1:0]      sync_q;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            level_q, level_d;

      // The run counter only grows while the synced level disagrees with the accepted one.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) level_d = sync_q[1];
          else                                  cnt_d   = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          sync_q  <= {sync_q[0], btn_raw[gi]};
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign btn_level_q[gi] = level_q;
      assign btn_level_d[gi] = level_d;
    end
  endgenerate

  assign mode_press = btn_level_d[0] & ~btn_level_q[0];
  assign dir_press  = btn_level_d[1] & ~btn_level_q[1];

  logic [PRESCALE_W-1:0] presc_q;
  logic [PWM_W-1:0]      pwm_q;
  mode_e                 mode_q, mode_d;
  logic                  dir_down_q, dir_down_d;
  logic [LED_W-1:0]      count_q, count_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  scan_down_q, scan_down_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic                  br_down_q, br_down_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic                  tick;
  logic [PWM_W-1:0]      duty_inc, duty_dec;

  assign tick     = &presc_q;
  assign duty_inc = duty_q + PWM_W'(1);
  assign duty_dec = duty_q - PWM_W'(1);

  always_comb begin
    mode_d      = mode_q;
    dir_down_d  = dir_down_q ^ dir_press;
    count_d     = count_q;
    pos_d       = pos_q;
    scan_down_d = scan_down_q ^ (dir_press && (mode_q == MODE_SCAN));
    duty_d      = duty_q;
    br_down_d   = br_down_q;
    // A mode press restarts the new pattern and overrides any tick in the same cycle.
    if (mode_press) begin
      mode_d      = mode_e'(mode_q + 2'd1);
      count_d     = '0;
      pos_d       = '0;
      scan_down_d = 1'b0;
      duty_d      = '0;
      br_down_d   = 1'b0;
    end else if (tick && !hold) begin
      case (mode_q)
        MODE_COUNT, MODE_GRAY: count_d = dir_down_d ? count_q - LED_W'(1) : count_q + LED_W'(1);
        MODE_SCAN: begin
          if (LED_W > 1) begin
            if (!scan_down_d) begin
              if (pos_q == POS_W'(LED_W - 1)) begin
                pos_d       = POS_W'(LED_W - 2);
                scan_down_d = 1'b1;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else if (pos_q == '0) begin
              pos_d       = POS_W'(1);
              scan_down_d = 1'b0;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        default: begin
          if (!br_down_q) begin
            duty_d = duty_inc;
            if (duty_inc == '1) br_down_d = 1'b1;
          end else begin
            duty_d = duty_dec;
            if (duty_dec == '0) br_down_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_COUNT: led_d = count_q;
      MODE_GRAY:  led_d = count_q ^ (count_q >> 1);
      MODE_SCAN:  led_d = LED_W'(1) << pos_q;
      default:    led_d = {LED_W{pwm_q < duty_q}};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q     <= '0;
      pwm_q       <= '0;
      mode_q      <= MODE_COUNT;
      dir_down_q  <= 1'b0;
      count_q     <= '0;
      pos_q       <= '0;
      scan_down_q <= 1'b0;
      duty_q      <= '0;
      br_down_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      presc_q     <= presc_q + PRESCALE_W'(1);
      pwm_q       <= pwm_q + PWM_W'(1);
      mode_q      <= mode_d;
      dir_down_q  <= dir_down_d;
      count_q     <= count_d;
      pos_q       <= pos_d;
      scan_down_q <= scan_down_d;
      duty_q      <= duty_d;
      br_down_q   <= br_down_d;
      led_q       <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_tick = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a cycle-level behavioural model.
module tb_led_pattern_gen;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_dir = 1'b0;
  logic [3:0] o_led;
  logic [1:0] o_mode;
  logic       o_tick;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  led_pattern_gen #(.LED_W(4), .PRESCALE_W(4), .DEBOUNCE_CYC(DB), .PWM_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_mode(btn_mode), .i_btn_dir(btn_dir),
    .o_led(o_led), .o_mode(o_mode), .o_tick(o_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Button model: raw goes through a 2-stage pipe; a level is accepted once the last DB
  // synced samples all disagree with it.
  typedef struct packed {
    bit [1:0]    pipe;
    bit [DB-1:0] seen;
    bit          lvl;
    bit          press;
  } btn_m_t;

  typedef struct {
    btn_m_t bm, bd;
    int mode, dir_down, count, pos, scan_down, duty, br_down, presc, pwm, led;
  } model_t;

  model_t m;

  function automatic btn_m_t btn_next(btn_m_t b, bit raw);
    btn_m_t n;
    n.seen  = {b.seen[DB-2:0], b.pipe[1]};
    n.pipe  = {b.pipe[0], raw};
    n.lvl   = b.lvl;
    n.press = 1'b0;
    if (n.seen == {DB{~b.lvl}}) begin
      n.lvl   = ~b.lvl;
      n.press = ~b.lvl;
    end
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n.bm = '0; n.bd = '0;
    n.mode = 0; n.dir_down = 0; n.count = 0; n.pos = 0; n.scan_down = 0;
    n.duty = 0; n.br_down = 0; n.presc = 0; n.pwm = 0; n.led = 0;
    return n;
  endfunction

  function automatic model_t model_next(model_t s, bit raw_m, bit raw_d);
    model_t n;
    n = s;
    n.bm = btn_next(s.bm, raw_m);
    n.bd = btn_next(s.bd, raw_d);
    case (s.mode)
      0: n.led = s.count;
      1: n.led = s.count ^ (s.count >> 1);
      2: n.led = 1 << s.pos;
      default: n.led = (s.pwm < s.duty) ? 15 : 0;
    endcase
    n.presc = (s.presc + 1) % 16;
    n.pwm = (s.pwm + 1) % 8;
    if (n.bd.press) begin
      n.dir_down = 1 - s.dir_down;
      if (s.mode == 2) n.scan_down = 1 - s.scan_down;
    end
    if (n.bm.press) begin
      n.mode = (s.mode + 1) % 4;
      n.count = 0; n.pos = 0; n.scan_down = 0; n.duty = 0; n.br_down = 0;
    end else if (s.presc == 15) begin
      case (s.mode)
        0, 1: n.count = (s.count + (n.dir_down != 0 ? 15 : 1)) % 16;
        2: begin
          if (n.scan_down == 0) begin
            if (s.pos == 3) begin n.pos = 2; n.scan_down = 1; end
            else n.pos = s.pos + 1;
          end else begin
            if (s.pos == 0) begin n.pos = 1; n.scan_down = 0; end
            else n.pos = s.pos - 1;
          end
        end
        default: begin
          if (s.br_down == 0) begin
            n.duty = s.duty + 1;
            if (n.duty == 7) n.br_down = 1;
          end else begin
            n.duty = s.duty - 1;
            if (n.duty == 0) n.br_down = 0;
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, btn_mode, btn_dir);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      tests++;
      if (o_led !== 4'(m.led) || o_mode !== 2'(m.mode) || o_tick !== (m.presc == 15)) begin
        failed++;
        $display("FAIL model_cmp @%0t: got led=%b mode=%0d tick=%b, expected led=%b mode=%0d tick=%b",
                 $time, o_led, o_mode, o_tick, 4'(m.led), 2'(m.mode), (m.presc == 15));
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_tick !== 1'b1 && n < 40);
    if (o_tick !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL wait_tick: got no o_tick in 40 cycles, expected one every 16");
    end
  endtask

  task automatic after_tick();
    wait_tick();
    repeat (2) @(negedge clk);
  endtask

  task automatic hold_btn(input int which, input int cycles);
    if (which == 0) btn_mode = 1'b1; else btn_dir = 1'b1;
    repeat (cycles) @(negedge clk);
    if (which == 0) btn_mode = 1'b0; else btn_dir = 1'b0;
  endtask

  initial begin
    #500000;
    failed++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, t1, ones;
    int scan_exp[8] = '{2, 4, 8, 4, 2, 1, 2, 4};
    int duty_exp[14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_led", int'(o_led), 0);
    check("reset_mode", int'(o_mode), 0);
    check("reset_tick", int'(o_tick), 0);
    rst_n = 1'b1;

    // COUNT from reset
    wait_tick(); t0 = cyc;
    repeat (2) @(negedge clk);
    check("count_1", int'(o_led), 1);
    wait_tick(); t1 = cyc;
    check("tick_period", t1 - t0, 16);
    repeat (2) @(negedge clk);
    check("count_2", int'(o_led), 2);
    after_tick();
    check("count_3", int'(o_led), 3);

    // Short pulse and glitchy hold must not advance the mode
    hold_btn(0, 3);
    repeat (10) @(negedge clk);
    check("short_pulse_mode", int'(o_mode), 0);
    for (int i = 0; i < 20; i++) begin
      btn_mode = (i % 3 != 2);
      @(negedge clk);
    end
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_mode", int'(o_mode), 0);

    // dir -> down, then clean mode press just after a tick -> GRAY with count 0
    hold_btn(1, 8);
    repeat (8) @(negedge clk);
    wait_tick();
    hold_btn(0, 10);
    check("mode_adv", int'(o_mode), 1);
    after_tick();
    check("gray_15", int'(o_led), 8);
    after_tick();
    check("gray_14", int'(o_led), 9);
    after_tick();
    check("gray_13", int'(o_led), 11);
    check("one_advance", int'(o_mode), 1);

    // SCAN
    wait_tick();
    hold_btn(0, 10);
    check("scan_mode", int'(o_mode), 2);
    check("scan_start", int'(o_led), 1);
    for (int i = 0; i < 8; i++) begin
      after_tick();
      check("scan_seq", int'(o_led), scan_exp[i]);
    end
    hold_btn(1, 8);
    after_tick();
    check("scan_dir", int'(o_led), 2);

    // BREATHE
    wait_tick();
    hold_btn(0, 10);
    ones = 0;
    for (int j = 0; j < 5; j++) begin
      if (o_led != 4'd0) ones++;
      @(negedge clk);
    end
    check("breathe_off", ones, 0);
    for (int k = 0; k < 14; k++) begin
      after_tick();
      ones = 0;
      for (int j = 0; j < 8; j++) begin
        if (o_led == 4'hF) ones++;
        @(negedge clk);
      end
      check("breathe_duty", ones, duty_exp[k]);
    end

    // Back to COUNT, then a mode press landing exactly on the tick at count=5
    wait_tick();
    hold_btn(0, 10);
    check("count_mode", int'(o_mode), 0);
    repeat (5) wait_tick();
    repeat (2) @(negedge clk);
    check("count_5", int'(o_led), 5);
    repeat (9) @(negedge clk);
    hold_btn(0, 10);
    check("coinc_mode", int'(o_mode), 1);
    check("coinc_count", int'(o_led), 0);

    // Async reset in the middle of a debounce
    after_tick();
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", int'(o_led), 0);
    check("arst_mode", int'(o_mode), 0);
    check("arst_tick", int'(o_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random button activity, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      btn_mode = 1'($urandom_range(0, 1));
      btn_dir  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 10)) @(negedge clk);
      if (i == 150) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
